// File: rtl/time_keeper.sv
// Time-of-day counter (hh:mm:ss) with debounced push-buttons and an hour-set mode.
// Feeds a clean button pulse and the current hour to the light controller.
module time_keeper #(
  parameter int CLK_HZ          = 1000,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int RESET_HOUR      = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  input  logic       set_raw,
  input  logic       set_mode,
  output logic       button,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic       tick_1s,
  output logic       in_set
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] SET = 1'b1;

  // Bit 0: btn_raw, bit 1: set_raw, bit 2: set_mode
  logic [2:0] sync1_reg;
  logic [2:0] sync2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= {set_mode, set_raw, btn_raw};
      sync2_reg <= sync1_reg;
    end
  end

  // press[0]: btn_raw press, press[1]: set_raw press; each high for one cycle
  // after the stable level rises.
  logic [1:0] press;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_db
      logic [DW-1:0] cnt_reg;
      logic          stable_reg;
      logic          press_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg    <= '0;
          stable_reg <= 1'b0;
          press_reg  <= 1'b0;
        end else begin
          press_reg <= 1'b0;
          if (sync2_reg[gi] == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DW'(DEBOUNCE_CYCLES - 1)) begin
            stable_reg <= sync2_reg[gi];
            cnt_reg    <= '0;
            press_reg  <= sync2_reg[gi];
          end else begin
            cnt_reg <= cnt_reg + DW'(1);
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  logic [0:0]    state_reg;
  logic [PW-1:0] presc_reg;
  logic [4:0]    hour_reg;
  logic [5:0]    minute_reg;
  logic [5:0]    second_reg;
  logic          tick_reg;
  logic          button_reg;

  // All decisions use state_reg as it was before the edge, so events that
  // coincide with a mode change follow the old mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= RUN;
      presc_reg  <= '0;
      hour_reg   <= 5'(RESET_HOUR);
      minute_reg <= '0;
      second_reg <= '0;
      tick_reg   <= 1'b0;
      button_reg <= 1'b0;
    end else begin
      state_reg  <= sync2_reg[2] ? SET : RUN;
      button_reg <= press[0] && (state_reg == RUN);

      if (state_reg == SET) begin
        presc_reg  <= '0;
        second_reg <= '0;
        tick_reg   <= 1'b0;
        if (press[1]) begin
          hour_reg <= (hour_reg == 5'd23) ? 5'd0 : hour_reg + 5'd1;
        end
      end else if (presc_reg == PW'(CLK_HZ - 1)) begin
        presc_reg <= '0;
        tick_reg  <= 1'b1;
        if (second_reg == 6'd59) begin
          second_reg <= '0;
          if (minute_reg == 6'd59) begin
            minute_reg <= '0;
            hour_reg   <= (hour_reg == 5'd23) ? 5'd0 : hour_reg + 5'd1;
          end else begin
            minute_reg <= minute_reg + 6'd1;
          end
        end else begin
          second_reg <= second_reg + 6'd1;
        end
      end else begin
        presc_reg <= presc_reg + PW'(1);
        tick_reg  <= 1'b0;
      end
    end
  end

  assign button  = button_reg;
  assign hour    = hour_reg;
  assign minute  = minute_reg;
  assign second  = second_reg;
  assign tick_1s = tick_reg;
  assign in_set  = state_reg;

endmodule

// File: doc/time_keeper.md
# time_keeper

Time-of-day and push-button front end feeding the LED light controller. It turns the raw board clock into a 24-hour hour/minute/second count and turns the bouncy raw push-button into a clean single-cycle press pulse. It also provides a set mode for adjusting the hour. Its `button` and `hour` outputs drive the light controller's `button` and `hour` inputs directly.

## Interface
- CLK_HZ, 1000, clk cycles per second; prescaler wraps at CLK_HZ-1 (≥2)
- DEBOUNCE_CYCLES, 20, consecutive stable cycles required before a debounced level changes (≥1)
- RESET_HOUR, 0, hour value loaded on reset (0..23)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- btn_raw  in  1  raw on/off push-button, asynchronous, bouncy
- set_raw  in  1  raw hour-set push-button, asynchronous, bouncy
- set_mode  in  1  level switch, asynchronous; 1 = SET, 0 = RUN
- button  out  1  one-cycle pulse per debounced btn_raw press
- hour  out  5  hours 0..23
- minute  out  6  minutes 0..59
- second  out  6  seconds 0..59
- tick_1s  out  1  one-cycle pulse each elapsed second (RUN only)
- in_set  out  1  1 while FSM is in SET

## Operation
- Synchronizers: btn_raw, set_raw and set_mode each pass through a 2-flop synchronizer before use.
- Debouncer (one per button): holds a stable level and a counter of width clog2(DEBOUNCE_CYCLES+1).
  - Synchronized input equal to the stable level: counter cleared.
  - Input differs: counter increments.
  - When the counter would reach DEBOUNCE_CYCLES: stable level flips and counter clears.
  - A press event is a 0→1 flip of the stable level. A 1→0 flip produces no event.
- FSM, two states:
  - RUN → SET when synchronized set_mode = 1.
  - SET → RUN when synchronized set_mode = 0.
  - in_set is registered and equals (state == SET).
- RUN:
  - Prescaler counts 0..CLK_HZ-1.
  - On the wrap edge: tick_1s = 1 for one cycle and second increments.
  - second 59→0 carries into minute; minute 59→0 carries into hour; hour 23→0 with no further carry.
  - A btn_raw press event sets button = 1 for one cycle.
  - set_raw press events are ignored.
- SET:
  - Prescaler and second are held at 0; minute is frozen; tick_1s = 0.
  - A set_raw press event increments hour, wrapping 23→0. minute is unaffected.
  - btn_raw press events are discarded: no button pulse.
  - Debouncers keep running, so a press held across a mode change produces no second event.
- Re-entering RUN: prescaler restarts from 0. The first tick_1s arrives CLK_HZ edges after the transition edge.
- Event coinciding with a mode transition: acted on according to the state before that edge.

## Timing
- Reset (async assert, sync use after deassert):
  - hour = RESET_HOUR; minute = second = 0.
  - button = tick_1s = in_set = 0.
  - Prescaler, debounce counters and stable levels = 0; FSM = RUN.
- Reset asserted mid-count or mid-debounce: all state returns to reset values immediately.
- Press latency: btn_raw first sampled 1 at edge E, and held at 1 from E onward. button is high from edge E+DEBOUNCE_CYCLES+2 for exactly one cycle. set_raw has the same latency to the hour increment.
- A bounce shorter than DEBOUNCE_CYCLES consecutive synchronized cycles produces no event. Each bounce clears the count.
- Mode latency: in_set changes at edge E+2 after set_mode is first sampled changed at edge E.
- tick_1s period is exactly CLK_HZ cycles in RUN. second/minute/hour update on the same edge that raises tick_1s.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset/rollover: CLK_HZ=4, RESET_HOUR=23, force time 23:59:59 via SET + run → tick_1s every 4 cycles; after the rollover tick, hour=0, minute=0, second=0.
- Debounce reject: DEBOUNCE_CYCLES=3; btn_raw pulses of 1–2 cycles, repeated 10 times → button never asserts.
- Debounce accept: btn_raw held high 20 cycles from edge E → button high only in the cycle after edge E+5; release yields no pulse.
- Hour set: set_mode=1 then 25 set_raw presses starting from hour=0 → hour=1 (wraps 23→0), second=0, tick_1s silent, button pulses suppressed during btn_raw presses.
- Resume: set_mode→0 at edge T, in_set falls at T+2 → first tick_1s exactly CLK_HZ edges after T+2, second=1 at that edge.
- Async reset mid-operation: assert rst_n=0 mid-debounce with hour=7 → all outputs reset at once; a held btn_raw after deassert needs full DEBOUNCE_CYCLES+2 latency.
